// File: rtl/uart_rx.sv
// Asynchronous serial receiver: start + word_width data bits (LSB first) + stop, sampled at mid-bit.
// Define UART_RX_PARITY_EN to expect one even-parity bit between the data and the stop bit.
module uart_rx #(
  parameter int base_freq  = 100_000_000,
  parameter int uart_speed = 10_000_000,
  parameter int word_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  output logic [word_width-1:0] rx_byte,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  parity_err
);

  function automatic int clogb2(input int value);
    int res;
    res = 0;
    while ((32'sd1 <<< res) < value) begin
      res = res + 32'sd1;
    end
    return res;
  endfunction

  localparam int takt = base_freq / uart_speed;
  localparam int CW   = clogb2(takt);
  localparam int IW   = clogb2(word_width + 1);

  localparam logic [CW-1:0] CNT_HALF = CW'(takt / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(takt - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(word_width - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif

  logic                  sync1_q, rxs_q, rxs_dly_q;
  logic                  fall_s;
  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [word_width-1:0] shift_q, shift_d;
  logic [word_width-1:0] rx_byte_q, rx_byte_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                  par_q, par_d;
  logic                  parity_err_q, parity_err_d;
`endif

  // Only a registered 1->0 transition starts a frame, so a stuck-low line never retriggers.
  assign fall_s = rxs_dly_q & ~rxs_q;

  // Two-stage synchroniser plus one delay stage for edge detection; idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b1;
      rxs_q     <= 1'b1;
      rxs_dly_q <= 1'b1;
    end else begin
      sync1_q   <= rxd;
      rxs_q     <= sync1_q;
      rxs_dly_q <= rxs_q;
    end
  end

  // Frame state machine and output pulse generation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (fall_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rxs_q) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[word_width-1:1]};
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = rxs_q;
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (rxs_q) begin
            rx_byte_d  = shift_q;
            rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = ^{shift_q, par_q};
`endif
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
